// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the fetch stage
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    FS_RUN,
    FS_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush; registered head, power-of-2 depth
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  // A pop frees the slot a same-cycle push needs, so push is legal at full.
  always_comb begin
    pop_ok  = pop && (cnt_q != '0);
    push_ok = push && ((cnt_q != CW'(DEPTH)) || pop_ok);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch stage: PC, in-order imem issue with credit limit, redirect/drain
module if_fetch_unit #(
  parameter int          XLEN       = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            if_ready
);

  import cpu_pkg::*;

  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam int BW = XLEN + 32;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d;

  logic            accept;
  logic            rsp_fire;
  logic [CW:0]     credit_used;

  logic            buf_push, buf_pop, buf_full, buf_empty;
  logic [BW-1:0]   buf_head;
  logic [CW-1:0]   buf_count;

  logic            tag_full, tag_empty;
  logic [XLEN-1:0] tag_head;
  logic [CW-1:0]   tag_count;
  logic            fetch_unused;

  always_comb begin
    credit_used    = {1'b0, outst_q} + {1'b0, buf_count};
    imem_req_valid = (state_q == FS_RUN) && !rst && !jump_flag && !stall
                     && (credit_used < (CW+1)'(IBUF_DEPTH)) && !tag_full;
    accept         = imem_req_valid && imem_req_ready;
    // Late responses after reset or a finished drain have no owner and are ignored.
    rsp_fire       = imem_rsp_valid && (outst_q != '0);
    outst_d        = outst_q + CW'(accept) - CW'(rsp_fire);
    buf_push       = (state_q == FS_RUN) && rsp_fire && !jump_flag && !tag_empty;
    buf_pop        = if_valid && if_ready;

    pc_d = pc_q;
    if (jump_flag)   pc_d = {jump_target[XLEN-1:2], 2'b00};
    else if (accept) pc_d = pc_q + XLEN'(INSTR_BYTES);

    state_d = state_q;
    if (jump_flag || (state_q == FS_DRAIN))
      state_d = (outst_d != '0) ? FS_DRAIN : FS_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_RUN;
      pc_q    <= XLEN'(RESET_PC);
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(IBUF_DEPTH)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .flush (jump_flag),
    .push  (accept),
    .wdata (pc_q),
    .pop   (rsp_fire),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  fetch_fifo #(.WIDTH(BW), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .flush (jump_flag),
    .push  (buf_push),
    .wdata ({tag_head, imem_rsp_data}),
    .pop   (buf_pop),
    .rdata (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign imem_req_addr = pc_q;
  assign if_valid      = !buf_empty;
  assign if_pc         = if_valid ? buf_head[BW-1:32] : '0;
  assign if_instr      = if_valid ? buf_head[31:0]    : '0;
  assign fetch_unused  = ^{jump_target[1:0], buf_full, tag_count};

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  logic [31:0] mq[$];
  int          allow = 0;
  bit          rsp_en = 1'b1;
  int          acc_count = 0;
  int          max_inflight = 0;
  bit          arm_first = 1'b0;
  logic [31:0] first_addr = '0;

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .IBUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .jump_flag(jump_flag), .jump_target(jump_target), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back({p, mem_word(p)});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_allow(input int n);
    allow = n;
    imem_req_ready = (n > 0);
  endtask

  task automatic set_rsp_en(input bit b);
    rsp_en = b;
    imem_rsp_valid = b && (mq.size() > 0);
  endtask

  task automatic do_jump(input logic [31:0] t);
    jump_target = t;
    jump_flag = 1'b1;
    step(1);
    jump_flag = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) step(1);
    step(2);
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_mq(input string name, input int n, input int limit);
    for (int i = 0; i < limit && mq.size() != n; i++) step(1);
    check(name, mq.size(), n);
  endtask

  // Memory model: in-order, one-cycle latency when responses are enabled.
  always begin
    logic        acc;
    logic [31:0] a;
    logic [31:0] tmp;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    if (imem_rsp_valid && mq.size() > 0) tmp = mq.pop_front();
    if (acc) begin
      mq.push_back(a);
      allow--;
      acc_count++;
      if (arm_first) begin
        first_addr = a;
        arm_first  = 1'b0;
      end
    end
    if (mq.size() > max_inflight) max_inflight = mq.size();
    imem_rsp_valid = rsp_en && (mq.size() > 0);
    imem_rsp_data  = (mq.size() > 0) ? mem_word(mq[0]) : 32'h0;
    imem_req_ready = (allow > 0);
  end

  // Monitor: every pop toward decode is checked against the scoreboard.
  always begin
    logic [63:0] e;
    @(negedge clk);
    if (!rst && if_valid && if_ready && !jump_flag) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: actual pc=%h instr=%h required no entry", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", if_pc, e[63:32]);
        check("pop_instr", if_instr, e[31:0]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c0;
    rst = 1'b1; jump_flag = 1'b0; jump_target = '0; stall = 1'b0;
    if_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    step(3);
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_req_addr", imem_req_addr, 0);

    // 1) streaming fetch
    if_ready = 1'b1;
    set_allow(8);
    for (int i = 0; i < 8; i++) expect_pc(32'(4 * i));
    rst = 1'b0;
    wait_drain("t1_drain", 100);
    check("t1_pc_after", imem_req_addr, 32'h20);

    // 2) decode backpressure
    if_ready = 1'b0;
    set_allow(6);
    for (int i = 0; i < 6; i++) expect_pc(32'h20 + 32'(4 * i));
    step(10);
    check("t2_if_valid", 32'(if_valid), 1);
    check("t2_req_blocked", 32'(imem_req_valid), 0);
    check("t2_buf_count", 32'(dut.buf_count), 2);
    check("t2_head_pc", if_pc, 32'h20);
    if_ready = 1'b1;
    wait_drain("t2_drain", 100);
    check("t2_pc_after", imem_req_addr, 32'h38);

    // 3) redirect with two in flight
    set_rsp_en(1'b0);
    set_allow(2);
    wait_mq("t3_inflight", 2, 20);
    check("t3_req_blocked", 32'(imem_req_valid), 0);
    do_jump(32'h100);
    check("t3_drain", 32'(dut.state_q), 32'(FS_DRAIN));
    check("t3_pc", imem_req_addr, 32'h100);
    arm_first = 1'b1;
    expect_pc(32'h100);
    set_allow(1);
    set_rsp_en(1'b1);
    wait_drain("t3_drain_done", 50);
    check("t3_first_addr", first_addr, 32'h100);
    check("t3_run", 32'(dut.state_q), 32'(FS_RUN));

    // 4) redirect coincident with response and pop
    if_ready = 1'b0;
    set_allow(1);
    for (int i = 0; i < 20 && !if_valid; i++) step(1);
    check("t4_head", 32'(if_valid), 1);
    set_rsp_en(1'b0);
    set_allow(1);
    wait_mq("t4_inflight", 1, 20);
    set_rsp_en(1'b1);
    if_ready = 1'b1;
    check("t4_rsp_present", 32'(imem_rsp_valid), 1);
    do_jump(32'h203);
    check("t4_if_valid", 32'(if_valid), 0);
    check("t4_pc", imem_req_addr, 32'h200);
    check("t4_run", 32'(dut.state_q), 32'(FS_RUN));
    arm_first = 1'b1;
    expect_pc(32'h200);
    set_allow(1);
    wait_drain("t4_drain", 50);
    check("t4_first_addr", first_addr, 32'h200);

    // 5) second redirect while draining
    set_rsp_en(1'b0);
    set_allow(2);
    wait_mq("t5_inflight", 2, 20);
    do_jump(32'h300);
    check("t5_drain1", 32'(dut.state_q), 32'(FS_DRAIN));
    do_jump(32'h400);
    check("t5_drain2", 32'(dut.state_q), 32'(FS_DRAIN));
    check("t5_pc", imem_req_addr, 32'h400);
    arm_first = 1'b1;
    expect_pc(32'h400);
    set_allow(1);
    set_rsp_en(1'b1);
    wait_drain("t5_drain_done", 50);
    check("t5_first_addr", first_addr, 32'h400);

    // 6) stall at top of address space, then wrap
    stall = 1'b1;
    do_jump(32'hFFFF_FFFC);
    set_allow(2);
    c0 = 32'(acc_count);
    step(5);
    check("t6_req_blocked", 32'(imem_req_valid), 0);
    check("t6_no_accept", 32'(acc_count), c0);
    check("t6_pc", imem_req_addr, 32'hFFFF_FFFC);
    arm_first = 1'b1;
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    stall = 1'b0;
    wait_drain("t6_drain", 50);
    check("t6_first_addr", first_addr, 32'hFFFF_FFFC);
    check("t6_pc_wrap", imem_req_addr, 32'h4);

    check("max_inflight_le2", 32'(max_inflight <= 2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
